// File: rtl/blue_sequencer.sv
// Instruction issue / writeback controller for the blue datapath ALU.
// Optional single-step gate between EXEC and WB: define BLUE_SEQ_STEP_EN.
module blue_sequencer #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [15:0]   ra_init,
    input  logic [15:0]   rb_init,
`ifdef BLUE_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [15:0]   ins,
    output logic [15:0]   RA,
    output logic [15:0]   RB,
    input  logic [15:0]   RA_OUT,
    input  logic [15:0]   RB_OUT,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    // state    | meaning
    // IDLE     | waiting for start; program RAM writable
    // FETCH    | ins <= mem[pc]
    // EXEC     | ins/RA/RB stable, ALU settles
    // STEPWAIT | hold until step=1 (step build only)
    // WB       | capture ALU results, count down, advance pc
    // DONE     | run finished, completion pulse follows
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_STEPWAIT = 3'd3,
        S_WB       = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam int DEPTH = 2 ** AW;

    state_t      state;
    logic [AW:0] count;
    logic [15:0] mem [DEPTH];

    // Program RAM is deliberately not reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // busy/done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            RA    <= '0;
            RB    <= '0;
            ins   <= '0;
            pc    <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state == S_FETCH) || (state == S_EXEC) ||
                    (state == S_STEPWAIT) || (state == S_WB);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        RA    <= ra_init;
                        RB    <= rb_init;
                        pc    <= '0;
                        count <= len;
                        state <= (len == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    ins   <= mem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
`ifdef BLUE_SEQ_STEP_EN
                    state <= S_STEPWAIT;
`else
                    state <= S_WB;
`endif
                end
                S_STEPWAIT: begin
`ifdef BLUE_SEQ_STEP_EN
                    if (step) begin
                        state <= S_WB;
                    end
`else
                    state <= S_WB;
`endif
                end
                S_WB: begin
                    RA    <= RA_OUT;
                    RB    <= RB_OUT;
                    count <= count - 1'b1;
                    if (count == (AW+1)'(1)) begin
                        state <= S_DONE;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blue_sequencer.sv
// Bench for blue_sequencer: behavioural ALU, run-level model checked every cycle,
// plus literal end-of-run results.
module tb_blue_sequencer;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef BLUE_SEQ_STEP_EN
    localparam int CPI = 4;
`else
    localparam int CPI = 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [15:0]   ra_init = '0;
    logic [15:0]   rb_init = '0;
    logic          step = 1'b1;
    logic [15:0]   ins, RA, RB, RA_OUT, RB_OUT;
    logic [AW-1:0] pc;
    logic          busy, done;

    int vectors = 0;
    int miscompares = 0;

    blue_sequencer #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .len(len), .ra_init(ra_init),
        .rb_init(rb_init),
`ifdef BLUE_SEQ_STEP_EN
        .step(step),
`endif
        .ins(ins), .RA(RA), .RB(RB), .RA_OUT(RA_OUT), .RB_OUT(RB_OUT),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
        logic [15:0] ro, bo;
        ro = a;
        bo = b;
        case (op)
            3'd0: ro = a + b;
            3'd1: ro = a - b;
            3'd2: ro = a | b;
            3'd3: ro = a & b;
            3'd4: ro = a ^ b;
            3'd5: ro = a >> 1;
            3'd6: ro = b;
            3'd7: begin ro = b; bo = a; end
            default: ro = a;
        endcase
        return {ro, bo};
    endfunction

    always_comb begin
        logic [31:0] r;
        r = alu(ins[15:13], RA, RB);
        RA_OUT = r[31:16];
        RB_OUT = r[15:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model state: shadow of program RAM and per-instruction expected trace.
    logic [15:0] shadow [DEPTH];
    logic [15:0] exp_ra [DEPTH+1];
    logic [15:0] exp_rb [DEPTH+1];
    logic [15:0] exp_ins [DEPTH];
    logic [15:0] prev_ins = '0;
    int m_n = 0;
    int mon_k = 0;
    bit mon_en = 1'b0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic prepare(input int n, input logic [15:0] ra0, input logic [15:0] rb0);
        logic [31:0] r;
        exp_ra[0] = ra0;
        exp_rb[0] = rb0;
        for (int i = 0; i < n; i++) begin
            exp_ins[i]  = shadow[i % DEPTH];
            r           = alu(exp_ins[i][15:13], exp_ra[i], exp_rb[i]);
            exp_ra[i+1] = r[31:16];
            exp_rb[i+1] = r[15:0];
        end
    endtask

    // Cycle k = the cycle after the k-th edge following the start edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int k, ii, ri, pe;
            logic [15:0] ie;
            k  = mon_k;
            ie = (m_n == 0 || k < 1) ? prev_ins : exp_ins[imin((k - 1) / CPI, m_n - 1)];
            ri = imin(k / CPI, m_n);
            pe = (m_n == 0) ? 0 : imin(k / CPI, m_n - 1);
            ii = (k >= 1 && k <= CPI * m_n) ? 1 : 0;
            chk("busy", 32'(busy), 32'(ii));
            chk("done", 32'(done), (k == CPI * m_n + 1) ? 32'd1 : 32'd0);
            chk("ins", 32'(ins), 32'(ie));
            chk("RA", 32'(RA), 32'(exp_ra[ri]));
            chk("RB", 32'(RB), 32'(exp_rb[ri]));
            chk("pc", 32'(pc), 32'(pe));
            mon_k = mon_k + 1;
            if (mon_k > CPI * m_n + 2) mon_en = 1'b0;
        end
    end

    task automatic write_prog(input int addr, input logic [15:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        shadow[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Start a run; optional same-cycle RAM write, optional writes/starts while busy.
    task automatic launch(input int n, input logic [15:0] ra0, input logic [15:0] rb0,
                          input bit monitor, input bit sim_we, input int sim_addr,
                          input logic [15:0] sim_data, input bit poke);
        @(negedge clk);
        if (sim_we) begin
            prog_we   = 1'b1;
            prog_addr = AW'(sim_addr);
            prog_data = sim_data;
            shadow[sim_addr] = sim_data;
        end
        prepare(n, ra0, rb0);
        len     = (AW+1)'(n);
        ra_init = ra0;
        rb_init = rb0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        if (monitor) begin
            m_n    = n;
            mon_k  = 0;
            mon_en = 1'b1;
            if (poke) begin
                @(negedge clk);
                prog_we   = 1'b1;
                prog_addr = AW'(1);
                prog_data = 16'hA5A5;
                start     = 1'b1;
                len       = (AW+1)'(1);
                ra_init   = 16'h7777;
                repeat (2) @(negedge clk);
                prog_we = 1'b0;
                start   = 1'b0;
            end
            for (int t = 0; t < 200 && mon_en; t++) @(posedge clk);
            if (mon_en) begin
                chk("run_timeout", 32'd1, 32'd0);
                mon_en = 1'b0;
            end
            if (n > 0) prev_ins = exp_ins[n-1];
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_RA", 32'(RA), 32'd0);
        chk("rst_RB", 32'(RB), 32'd0);
        chk("rst_ins", 32'(ins), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Single ADD
        write_prog(0, 16'h0000);
        launch(1, 16'd3, 16'd5, 1'b1, 1'b0, 0, 16'h0, 1'b0);
        chk("add_RA", 32'(RA), 32'd8);
        chk("add_RB", 32'(RB), 32'd5);

        // ADD, EXCH, SUB
        write_prog(1, 16'hE000);
        write_prog(2, 16'h2000);
        launch(3, 16'd10, 16'd4, 1'b1, 1'b0, 0, 16'h0, 1'b0);
        chk("p3_RA", 32'(RA), 32'h0000FFF6);
        chk("p3_RB", 32'(RB), 32'd14);
        chk("p3_pc", 32'(pc), 32'd2);

        // len = 0
        launch(0, 16'h1234, 16'h5678, 1'b1, 1'b0, 0, 16'h0, 1'b0);
        chk("len0_RA", 32'(RA), 32'h1234);
        chk("len0_RB", 32'(RB), 32'h5678);
        chk("len0_ins", 32'(ins), 32'h2000);

        // Reset during the second instruction's EXEC
        launch(2, 16'd1, 16'd2, 1'b0, 1'b0, 0, 16'h0, 1'b0);
        repeat (CPI + 1) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_RA", 32'(RA), 32'd0);
        chk("abort_RB", 32'(RB), 32'd0);
        chk("abort_ins", 32'(ins), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        prev_ins = '0;
        launch(1, 16'd7, 16'd9, 1'b1, 1'b0, 0, 16'h0, 1'b0);
        chk("rerun_RA", 32'(RA), 32'd16);

        // Full-depth run with same-cycle write of word 3 and pokes while busy
        launch(4, 16'd5, 16'd3, 1'b1, 1'b1, 3, 16'h4ABC, 1'b1);
        chk("full_RA", 32'(RA), 32'h0000FFFB);
        chk("full_RB", 32'(RB), 32'd8);
        chk("full_pc", 32'(pc), 32'd3);
        chk("full_ins", 32'(ins), 32'h4ABC);

`ifdef BLUE_SEQ_STEP_EN
        step = 1'b0;
        launch(1, 16'd3, 16'd5, 1'b0, 1'b0, 0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("hold_RA", 32'(RA), 32'd3);
            chk("hold_RB", 32'(RB), 32'd5);
            chk("hold_ins", 32'(ins), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        chk("step_pre_RA", 32'(RA), 32'd3);
        @(posedge clk);
        #1;
        chk("step_RA", 32'(RA), 32'd8);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("step_done", 32'(seen), 32'd1);
        step = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/blue_sequencer.md
Name: blue_sequencer

Overview:
- Instruction issue and writeback controller for the blue datapath ALU, which is the combinational RA/RB/ins -> RA_OUT/RB_OUT block.
- Holds a small program RAM and the RA/RB working registers.
- Presents one instruction at a time to the ALU, captures the ALU results back into RA/RB, and steps a PC until the programmed length is exhausted.

Parameters:
- AW, 4, program address width; program depth = 2**AW words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program RAM write strobe; honoured only while idle.
- prog_addr  in  AW  program RAM write address.
- prog_data  in  16  program word; bits [15:13] are the ALU opcode, bits [12:0] are passed through unchanged.
- start  in  1  run request; sampled only while idle.
- len  in  AW+1  number of instructions to execute, 0..2**AW.
- ra_init  in  16  RA start value, loaded on an accepted start.
- rb_init  in  16  RB start value, loaded on an accepted start.
- ins  out  16  instruction word driven to the ALU.
- RA  out  16  RA register driven to the ALU.
- RB  out  16  RB register driven to the ALU.
- RA_OUT  in  16  ALU result for RA.
- RB_OUT  in  16  ALU result for RB.
- pc  out  AW  current program counter.
- busy  out  1  high in FETCH, EXEC and WB.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, RA=RB=0, ins=0, pc=0, busy=0, done=0, internal count=0.
  - Program RAM contents are not reset.
  - Reset mid-run aborts immediately; no done pulse.
- Opcodes, ins[15:13]: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SHR, 6 MOV, 7 EXCH. The sequencer never interprets the opcode.
- Program RAM write: occurs at the clock edge when prog_we=1 and state=IDLE. Writes while not idle are dropped.
- IDLE:
  - On start=1, load RA=ra_init, RB=rb_init, pc=0, count=len.
  - If len=0, go to DONE; otherwise go to FETCH.
  - start while busy is ignored.
  - prog_we and start in the same cycle: the write completes, and the run uses the RAM contents after the write.
- FETCH: ins <= mem[pc] (registered read); go to EXEC.
- EXEC:
  - ins, RA and RB are stable for the whole cycle and the ALU settles.
  - Go to WB (or STEPWAIT if the optional feature is on).
- WB:
  - RA <= RA_OUT, RB <= RB_OUT, count <= count-1.
  - If count was 1: go to DONE, and pc holds.
  - Otherwise: pc <= pc+1 (wraps modulo 2**AW) and go to FETCH.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. RA/RB hold final results until the next accepted start.
- Timing: 3 cycles per instruction. With start sampled at edge 0:
  - For len=N>0, the last WB edge is 3N and done is high in the cycle following edge 3N+1.
  - For len=0, done is high after edge 1.
- len = 2**AW executes every word once; len above that is not possible by width.
- ins holds its last value in IDLE/DONE.
- Outputs are registered; there is no combinational path from the inputs to the outputs.

Optional Feature:
- Macro: BLUE_SEQ_STEP_EN.
- When defined:
  - Adds input step (1 bit) and state STEPWAIT between EXEC and WB.
  - In STEPWAIT, ins/RA/RB are held and the block moves to WB only on a cycle with step=1.
  - step in any other state is ignored.
  - busy stays 1 in STEPWAIT.
- When undefined: there is no step port and EXEC goes directly to WB (3-cycle cadence).

Test Plan:
Benches use a behavioural ALU model: ADD -> RA_OUT=RA+RB, RB_OUT=RB; SUB -> RA-RB; EXCH -> swap RA and RB.
- Single ADD: mem[0]=16'h0000, ra_init=3, rb_init=5, len=1, start -> RA=8, RB=5, done pulses once at cycle 4 after start, busy high in cycles 1-3.
- Three-instruction program: ADD, EXCH, SUB at words 0-2; ra_init=10, rb_init=4 -> after ADD RA=14, RB=4; after EXCH RA=4, RB=14; after SUB RA=0xFFF6, RB=14. Done after 3 instructions; pc=2.
- len=0 with start -> done one cycle later, RA=ra_init, RB=rb_init, no ins change.
- Assert reset mid-run during the second instruction's EXEC -> all outputs return to 0 asynchronously with no done. A following start with len=1 runs correctly from pc=0.
- Issue prog_we to mem[1] and a second start while busy -> RAM unchanged, run unaffected. With AW=2 and len=4, pc sequences 0,1,2,3 and no wrap fault.
- With BLUE_SEQ_STEP_EN: hold step=0 for 5 cycles in STEPWAIT -> RA/RB/ins unchanged. Pulse step=1 -> WB occurs on the next edge.
